// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, single-outstanding imem requests, and a small {pc, insn} buffer toward decode.
// Optional FETCH_PERF_EN adds a 32-bit count of instructions accepted by decode (perf_fetched).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched
`endif
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        pc;
  logic [31:0]        req_pc;
  logic [31:0]        buf_pc   [BUF_DEPTH];
  logic [31:0]        buf_insn [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   outstanding;
  logic               has_space;
  logic               empty;
  logic               full;
  logic               req_fire;
  logic               push;
  logic               pop;
  logic               unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // The request slot counts the in-flight fetch so a response always has a free entry.
  assign outstanding = {{PTR_W{1'b0}}, (state != S_REQ)};
  assign has_space   = (count + outstanding) < CNT_W'(BUF_DEPTH);
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(BUF_DEPTH));

  assign imem_req_valid = !rst && (state == S_REQ) && has_space && !redirect_valid;
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;

  assign id_valid       = !empty && !redirect_valid;
  assign id_instruction = empty ? NOP : buf_insn[rd_ptr];
  assign id_pc          = empty ? RESET_PC : buf_pc[rd_ptr];
  assign pop            = id_valid && id_ready;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
      // A response still owed by memory must be swallowed before fetching the target.
      if (state == S_REQ || imem_rsp_valid) state <= S_REQ;
      else                                  state <= S_DROP;
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= S_WAIT;
          end
        end
        S_WAIT:  if (imem_rsp_valid) state <= S_REQ;
        S_DROP:  if (imem_rsp_valid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: buffer storage has no reset; occupancy is tracked by count and
  // the outputs are masked to NOP/RESET_PC while it is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= req_pc;
      buf_insn[wr_ptr] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      perf_fetched <= '0;
    else if (pop) perf_fetched <= perf_fetched + 32'd1;
  end
`endif

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule
